// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared fetch constants, IF/ID entry type and PC alignment helper
package riscv_defines;

    localparam logic [31:0] BOOT_ADDR      = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam int unsigned PREFETCH_DEPTH = 2;
    localparam int unsigned FIFO_CNT_W     = $clog2(PREFETCH_DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction memory req/gnt/rvalid bus
interface if_stage_if;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;

    modport master (output instr_req, instr_addr, input instr_gnt, instr_rvalid, instr_rdata);
    modport slave  (input instr_req, instr_addr, output instr_gnt, instr_rvalid, instr_rdata);
endinterface

// File: rtl/if_stage_prefetch_fifo.sv
// rtl/if_stage_prefetch_fifo.sv - small circular prefetch FIFO with flush
module prefetch_fifo #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned WIDTH = 64,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot in the same cycle, so push-on-full is legal alongside it.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = push_data_i;
                wr_d        = ptr_inc(wr_q);
            end
            if (do_pop) begin
                rd_d = ptr_inc(rd_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: single-outstanding fetch FSM, prefetch FIFO, IF/ID register
module if_stage
    import riscv_defines::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_stall_i,
    input  logic        if_to_id_stall_i,
    input  logic        if_to_id_clear_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    if_stage_if.master  instr_bus,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        instr_valid_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DISCARD} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d, inflight_pc_q, inflight_pc_d;
    logic            req_hold_q, req_hold_d;
    logic [31:0]     instr_q, instr_d, pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            req, resp_accept, load;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_count;
    fetch_entry_t    fifo_head, resp_entry;

    assign instr_bus.instr_req  = req;
    assign instr_bus.instr_addr = fetch_pc_q;
    assign resp_entry           = '{pc: inflight_pc_q, instr: instr_bus.instr_rdata};

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        req_hold_d    = req_hold_q;
        req           = 1'b0;
        resp_accept   = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                // Once raised, req stays up until granted so the address never changes under the slave.
                req = req_hold_q || (!fetch_stall_i && (fifo_count < FIFO_CNT_W'(PREFETCH_DEPTH)));
                if (req && instr_bus.instr_gnt) begin
                    state_d       = S_WAIT;
                    inflight_pc_d = fetch_pc_q;
                    fetch_pc_d    = fetch_pc_q + 32'd4;
                    req_hold_d    = 1'b0;
                end else begin
                    req_hold_d = req;
                end
            end
            S_WAIT: begin
                if (instr_bus.instr_rvalid) begin
                    state_d     = S_REQ;
                    resp_accept = !branch_taken_i;
                end
            end
            S_DISCARD: begin
                if (instr_bus.instr_rvalid) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
        if (branch_taken_i) begin
            fetch_pc_d = word_align(branch_target_i);
            req_hold_d = 1'b0;
            if ((state_q == S_REQ && req && instr_bus.instr_gnt) ||
                ((state_q == S_WAIT || state_q == S_DISCARD) && !instr_bus.instr_rvalid)) begin
                state_d = S_DISCARD;
            end
        end
    end

    assign load      = !if_to_id_clear_i && !if_to_id_stall_i;
    assign fifo_pop  = load && !fifo_empty && !branch_taken_i;
    assign fifo_push = resp_accept && !(load && fifo_empty) && (!fifo_full || fifo_pop);

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (if_to_id_clear_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!if_to_id_stall_i) begin
            if (!branch_taken_i && !fifo_empty) begin
                instr_d = fifo_head.instr;
                pc_d    = fifo_head.pc;
                valid_d = 1'b1;
            end else if (resp_accept) begin
                // Bypass: empty FIFO, the response lands straight in IF/ID.
                instr_d = resp_entry.instr;
                pc_d    = resp_entry.pc;
                valid_d = 1'b1;
            end else begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= BOOT_ADDR;
            inflight_pc_q <= BOOT_ADDR;
            req_hold_q    <= 1'b0;
            instr_q       <= NOP_INSTR;
            pc_q          <= 32'h0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            req_hold_q    <= req_hold_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            valid_q       <= valid_d;
        end
    end

    assign instr_o       = instr_q;
    assign pc_o          = pc_q;
    assign instr_valid_o = valid_q;

    prefetch_fifo #(.DEPTH(PREFETCH_DEPTH), .WIDTH($bits(fetch_entry_t))) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (branch_taken_i),
        .push_i      (fifo_push),
        .push_data_i (resp_entry),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage with randomized memory slave
module tb_if_stage;
    import riscv_defines::*;

    logic        clk = 1'b0;
    logic        rst_n, fetch_stall, id_stall, id_clear, branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instr_o, pc_o;
    logic        instr_valid_o;

    always #5 clk = ~clk;

    if_stage_if ibus ();

    if_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_stall_i    (fetch_stall),
        .if_to_id_stall_i (id_stall),
        .if_to_id_clear_i (id_clear),
        .branch_taken_i   (branch_taken),
        .branch_target_i  (branch_target),
        .instr_bus        (ibus.master),
        .instr_o          (instr_o),
        .pc_o             (pc_o),
        .instr_valid_o    (instr_valid_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } resp_t;

    int          n_cmp = 0, n_fail = 0, n_delivered = 0, cycle = 0;
    int          gnt_pct = 100, lat_min = 1, lat_max = 1;
    logic [31:0] exp_q[$];
    logic [31:0] hs_log[$];
    resp_t       pend_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Program-order model: after reset or a redirect, decode must see consecutive words from the start PC.
    task automatic model_restart(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back((start & ~32'h3) + 32'(4 * i));
    endtask

    // Memory slave: random grant, response 1..3 cycles after handshake, protocol checks.
    initial begin
        logic        p_wait;
        logic [31:0] p_addr;
        int          lat;
        p_wait = 1'b0;
        p_addr = '0;
        ibus.instr_gnt    = 1'b0;
        ibus.instr_rvalid = 1'b0;
        ibus.instr_rdata  = '0;
        forever begin
            @(posedge clk);
            cycle++;
            if (p_wait && rst_n) begin
                check("req_held", 64'(ibus.instr_req), 64'd1);
                check("addr_held", 64'(ibus.instr_addr), 64'(p_addr));
            end
            if (rst_n && ibus.instr_req && ibus.instr_gnt) begin
                check("one_outstanding", 64'(pend_q.size()), 64'd0);
                lat = $urandom_range(lat_max, lat_min);
                hs_log.push_back(ibus.instr_addr);
                pend_q.push_back('{addr: ibus.instr_addr, due: cycle + lat - 1});
            end
            p_wait = rst_n && ibus.instr_req && !ibus.instr_gnt && !branch_taken;
            p_addr = ibus.instr_addr;
            @(negedge clk);
            ibus.instr_rvalid = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].due <= cycle) begin
                ibus.instr_rvalid = 1'b1;
                ibus.instr_rdata  = mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
            end
            ibus.instr_gnt = ($urandom_range(99, 0) < gnt_pct);
        end
    end

    // Monitor: every IF/ID load that yields a valid instruction is compared with the model head.
    initial begin
        logic        s_load;
        logic [31:0] e;
        forever begin
            @(posedge clk);
            s_load = rst_n && !id_clear && !id_stall;
            #1;
            if (s_load && rst_n && instr_valid_o) begin
                e = exp_q.pop_front();
                if (exp_q.size() == 0) exp_q.push_back(e + 32'd4);
                check("pc_o", 64'(pc_o), 64'(e));
                check("instr_o", 64'(instr_o), 64'(mem_word(e)));
                n_delivered++;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 64'(ibus.instr_req), 64'd0);
        check({tag, "_addr"}, 64'(ibus.instr_addr), 64'(BOOT_ADDR));
        check({tag, "_instr"}, 64'(instr_o), 64'(NOP_INSTR));
        check({tag, "_pc"}, 64'(pc_o), 64'd0);
        check({tag, "_valid"}, 64'(instr_valid_o), 64'd0);
    endtask

    task automatic wait_handshake(input string tag);
        int n;
        n = hs_log.size();
        for (int i = 0; i < 60 && hs_log.size() == n; i++) @(negedge clk);
        if (hs_log.size() == n) check({tag, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic do_branch(input logic [31:0] target);
        branch_taken  = 1'b1;
        branch_target = target;
        id_clear      = 1'b1;
        model_restart(target);
        @(negedge clk);
        branch_taken = 1'b0;
        id_clear     = 1'b0;
    endtask

    initial begin
        logic [31:0] cap_pc, cap_instr;
        logic        cap_valid;
        int          n, k;
        rst_n = 1'b0; fetch_stall = 1'b0; id_stall = 1'b0; id_clear = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        model_restart(BOOT_ADDR);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Boot latency with gnt tied high and 1-cycle response.
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("boot_valid_c2", 64'(instr_valid_o), 64'd0);
        @(posedge clk);
        #1 check("boot_valid_c3", 64'(instr_valid_o), 64'd1);
        check("boot_pc_c3", 64'(pc_o), 64'd0);
        for (int i = 0; i < 60 && hs_log.size() < 3; i++) @(negedge clk);
        check("boot_hs_count", 64'(hs_log.size() >= 3), 64'd1);
        if (hs_log.size() >= 3) begin
            check("boot_addr0", 64'(hs_log[0]), 64'h0);
            check("boot_addr1", 64'(hs_log[1]), 64'h4);
            check("boot_addr2", 64'(hs_log[2]), 64'h8);
        end
        @(negedge clk);

        // Decode stall: outputs frozen, FIFO fills, fetch backs off.
        cap_pc = pc_o; cap_instr = instr_o; cap_valid = instr_valid_o;
        id_stall = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("stall_pc", 64'(pc_o), 64'(cap_pc));
            check("stall_instr", 64'(instr_o), 64'(cap_instr));
            check("stall_valid", 64'(instr_valid_o), 64'(cap_valid));
        end
        check("stall_fifo_count", 64'(dut.u_fifo.count_o), 64'd2);
        check("stall_req_low", 64'(ibus.instr_req), 64'd0);

        // Clear wins over stall.
        id_clear = 1'b1;
        @(negedge clk);
        check("clear_instr", 64'(instr_o), 64'(NOP_INSTR));
        check("clear_valid", 64'(instr_valid_o), 64'd0);
        id_clear = 1'b0;
        id_stall = 1'b0;
        repeat (8) @(negedge clk);

        // Redirect while a response is outstanding.
        lat_min = 3; lat_max = 3;
        wait_handshake("wait_hs");
        n = hs_log.size();
        do_branch(32'h0000_0103);
        for (int i = 0; i < 60 && hs_log.size() == n; i++) @(negedge clk);
        check("redirect_addr", 64'(hs_log.size() > n ? hs_log[n] : 32'hDEAD_BEEF), 64'h100);
        repeat (10) @(negedge clk);

        // PC wrap-around.
        lat_min = 1; lat_max = 1;
        n = hs_log.size();
        do_branch(32'hFFFF_FFFC);
        for (int i = 0; i < 60 && hs_log.size() < n + 3; i++) @(negedge clk);
        k = -1;
        for (int i = n; i < hs_log.size(); i++) if (k < 0 && hs_log[i] == 32'hFFFF_FFFC) k = i;
        check("wrap_target_seen", 64'(k >= 0), 64'd1);
        if (k >= 0 && k + 1 < hs_log.size()) check("wrap_next", 64'(hs_log[k+1]), 64'h0);
        repeat (6) @(negedge clk);

        // Reset in the middle of an outstanding fetch; response lands during reset.
        lat_min = 3; lat_max = 3;
        wait_handshake("rst_hs");
        rst_n = 1'b0;
        model_restart(BOOT_ADDR);
        #1 check_reset_outputs("midrst");
        repeat (5) @(negedge clk);
        check_reset_outputs("inrst");
        n = hs_log.size();
        lat_min = 1;
        rst_n = 1'b1;
        for (int i = 0; i < 60 && hs_log.size() == n; i++) @(negedge clk);
        check("post_rst_addr", 64'(hs_log.size() > n ? hs_log[n] : 32'hDEAD_BEEF), 64'(BOOT_ADDR));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) gnt_pct = $urandom_range(100, 30);
            fetch_stall  = ($urandom_range(5, 0) == 0);
            id_stall     = ($urandom_range(3, 0) == 0);
            id_clear     = ($urandom_range(24, 0) == 0);
            branch_taken = 1'b0;
            if ($urandom_range(39, 0) == 0) begin
                branch_taken  = 1'b1;
                id_clear      = 1'b1;
                branch_target = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15, 0))
                                                            : $urandom;
                model_restart(branch_target);
            end
            @(negedge clk);
        end
        fetch_stall = 1'b0; id_stall = 1'b0; id_clear = 1'b0; branch_taken = 1'b0;
        gnt_pct = 100;
        repeat (40) @(negedge clk);
        check("liveness", 64'(n_delivered > 300), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
